// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: memory-class opcodes, sequencer state encoding
// and small opcode classification helpers.
package lc3_pkg;

    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_STI = 4'b1011;

    // Read wait counter width; covers READ_WAIT in 0..7.
    localparam int WAIT_W = 3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MAR_EA  = 3'd1,
        S_WAIT1   = 3'd2,
        S_MAR_IND = 3'd3,
        S_WAIT2   = 3'd4,
        S_CAPTURE = 3'd5,
        S_WRITE   = 3'd6,
        S_BADOP   = 3'd7
    } state_t;

    // Any of the six opcodes this sequencer handles.
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI) ||
               (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
    endfunction

    // Stores that need no read before the write strobe.
    function automatic logic is_direct_store(input logic [3:0] op);
        return (op == OP_ST) || (op == OP_STR);
    endfunction

    // Loads whose single read goes straight to the register file.
    function automatic logic is_direct_load(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_LDR);
    endfunction

endpackage

// File: rtl/wait_counter.sv
// Down counter timing the gap between a MAR load and valid memory data.
// Loads a start value, decrements while enabled and holds at zero.
module wait_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Load has priority; decrement saturates at zero so the count never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// LC-3 data-memory access sequencer. Takes one memory-class opcode, steps
// MAR loads, read waits and the final register write or memory write, and
// pulses DONE in the last action cycle. All outputs are decoded from state.
//
// Handshake: START is only looked at in IDLE; when it is high there the
// request is accepted on that clock edge and OP is latched. START while
// BUSY is dropped, not queued. DONE marks the final cycle of a request and
// IDLE (ready for the next START) follows on the next cycle.
module mem_access_ctrl
    import lc3_pkg::*;
#(
    parameter int READ_WAIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       START,
    input  logic [3:0] OP,
    output logic       BUSY,
    output logic       DONE,
    output logic       ILLEGAL,
    output logic       MAR_LE,
    output logic       MAR_CONTROL,
    output logic       WE,
    output logic       REG_LE,
    output state_t     dbg_state
);

    // Counter start value so a wait state lasts exactly READ_WAIT cycles.
    localparam logic [WAIT_W-1:0] WAIT_LOAD =
        (READ_WAIT > 0) ? WAIT_W'(READ_WAIT - 1) : '0;
    localparam bit NO_WAIT = (READ_WAIT == 0);

    state_t     state;
    state_t     state_next;
    logic [3:0] op_q;
    logic       cnt_load;
    logic       cnt_dec;
    logic       cnt_zero;

    wait_counter #(
        .WIDTH (WAIT_W)
    ) u_wait_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (WAIT_LOAD),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

    // State register; reset aborts any request without a final strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Opcode is captured only on acceptance so later OP changes are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q <= 4'b0000;
        end else if ((state == S_IDLE) && START) begin
            op_q <= OP;
        end
    end

    // Next-state logic and wait counter control.
    always_comb begin
        state_next = state;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        case (state)
            S_IDLE: begin
                if (START) begin
                    state_next = is_mem_op(OP) ? S_MAR_EA : S_BADOP;
                end
            end
            S_MAR_EA: begin
                if (is_direct_store(op_q)) begin
                    state_next = S_WRITE;
                end else if (NO_WAIT) begin
                    state_next = is_direct_load(op_q) ? S_CAPTURE : S_MAR_IND;
                end else begin
                    state_next = S_WAIT1;
                    cnt_load   = 1'b1;
                end
            end
            S_WAIT1: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    state_next = is_direct_load(op_q) ? S_CAPTURE : S_MAR_IND;
                end
            end
            S_MAR_IND: begin
                if (op_q == OP_STI) begin
                    state_next = S_WRITE;
                end else if (NO_WAIT) begin
                    state_next = S_CAPTURE;
                end else begin
                    state_next = S_WAIT2;
                    cnt_load   = 1'b1;
                end
            end
            S_WAIT2: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    state_next = S_CAPTURE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Moore output decode; at most one of MAR_LE, WE, REG_LE per state.
    always_comb begin
        BUSY        = (state != S_IDLE);
        DONE        = 1'b0;
        ILLEGAL     = 1'b0;
        MAR_LE      = 1'b0;
        MAR_CONTROL = 1'b0;
        WE          = 1'b0;
        REG_LE      = 1'b0;
        case (state)
            S_MAR_EA:  MAR_LE = 1'b1;
            S_MAR_IND: begin
                MAR_LE      = 1'b1;
                MAR_CONTROL = 1'b1;
            end
            S_CAPTURE: begin
                REG_LE = 1'b1;
                DONE   = 1'b1;
            end
            S_WRITE: begin
                WE   = 1'b1;
                DONE = 1'b1;
            end
            S_BADOP: begin
                ILLEGAL = 1'b1;
                DONE    = 1'b1;
            end
            default: ;
        endcase
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl. Three instances (READ_WAIT = 0, 1, 3)
// share the same stimulus; each has its own expected-output queue that a
// per-instance monitor drains once per cycle on the falling edge.
module tb_mem_access_ctrl;
    import lc3_pkg::*;

    // Output row layout: {BUSY, DONE, ILLEGAL, MAR_LE, MAR_CONTROL, WE, REG_LE}
    localparam logic [6:0] R_IDL = 7'b0000000;
    localparam logic [6:0] R_EA  = 7'b1001000;
    localparam logic [6:0] R_WT  = 7'b1000000;
    localparam logic [6:0] R_IND = 7'b1001100;
    localparam logic [6:0] R_CAP = 7'b1100001;
    localparam logic [6:0] R_WR  = 7'b1100010;
    localparam logic [6:0] R_BAD = 7'b1110000;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] op = 4'b0000;

    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    logic   busy_0, done_0, ill_0, marle_0, marc_0, we_0, regle_0;
    logic   busy_1, done_1, ill_1, marle_1, marc_1, we_1, regle_1;
    logic   busy_3, done_3, ill_3, marle_3, marc_3, we_3, regle_3;
    state_t dbg_0, dbg_1, dbg_3;

    mem_access_ctrl #(.READ_WAIT(0)) dut_rw0 (
        .clk(clk), .reset(reset), .START(start), .OP(op),
        .BUSY(busy_0), .DONE(done_0), .ILLEGAL(ill_0), .MAR_LE(marle_0),
        .MAR_CONTROL(marc_0), .WE(we_0), .REG_LE(regle_0), .dbg_state(dbg_0)
    );
    mem_access_ctrl #(.READ_WAIT(1)) dut_rw1 (
        .clk(clk), .reset(reset), .START(start), .OP(op),
        .BUSY(busy_1), .DONE(done_1), .ILLEGAL(ill_1), .MAR_LE(marle_1),
        .MAR_CONTROL(marc_1), .WE(we_1), .REG_LE(regle_1), .dbg_state(dbg_1)
    );
    mem_access_ctrl #(.READ_WAIT(3)) dut_rw3 (
        .clk(clk), .reset(reset), .START(start), .OP(op),
        .BUSY(busy_3), .DONE(done_3), .ILLEGAL(ill_3), .MAR_LE(marle_3),
        .MAR_CONTROL(marc_3), .WE(we_3), .REG_LE(regle_3), .dbg_state(dbg_3)
    );

    logic [6:0] act_0, act_1, act_3;
    assign act_0 = {busy_0, done_0, ill_0, marle_0, marc_0, we_0, regle_0};
    assign act_1 = {busy_1, done_1, ill_1, marle_1, marc_1, we_1, regle_1};
    assign act_3 = {busy_3, done_3, ill_3, marle_3, marc_3, we_3, regle_3};

    // ---------------- scoreboard ----------------
    logic [6:0] exp_q0[$];
    logic [6:0] exp_q1[$];
    logic [6:0] exp_q3[$];
    logic [6:0] rows[$];
    string      tname = "reset";
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc   = 0;

    function automatic void compare(input string inst, input logic [6:0] act,
                                    input logic [6:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s/%s cycle %0d: got %b expected %b (BUSY DONE ILL MAR_LE MAR_CTRL WE REG_LE)",
                     tname, inst, cyc, act, exp);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // monitors: one expected row per cycle while the queue holds rows
    always @(negedge clk) begin
        if (exp_q0.size() > 0) compare("rw0", act_0, exp_q0.pop_front());
    end
    always @(negedge clk) begin
        if (exp_q1.size() > 0) compare("rw1", act_1, exp_q1.pop_front());
    end
    always @(negedge clk) begin
        if (exp_q3.size() > 0) compare("rw3", act_3, exp_q3.pop_front());
    end

    // ---------------- driver tasks ----------------
    // Copy the staged rows into the selected queues: bit0 rw0, bit1 rw1, bit2 rw3.
    task automatic load(input logic [2:0] which);
        foreach (rows[i]) begin
            if (which[0]) exp_q0.push_back(rows[i]);
            if (which[1]) exp_q1.push_back(rows[i]);
            if (which[2]) exp_q3.push_back(rows[i]);
        end
    endtask

    // Drive len cycles: START from start_mask, OP=op in the first cycle and
    // op_busy afterwards, reset high in cycle rst_at (-1 for none).
    task automatic issue(input logic [3:0] op_first, input logic [3:0] op_busy,
                         input logic [15:0] start_mask, input int rst_at,
                         input int len);
        for (int j = 0; j < len; j++) begin
            start = start_mask[j];
            op    = (j == 0) ? op_first : op_busy;
            reset = (j == rst_at);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        reset = 1'b0;
        if (exp_q0.size() + exp_q1.size() + exp_q3.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s drain: got %0d rows left expected 0", tname,
                     exp_q0.size() + exp_q1.size() + exp_q3.size());
            exp_q0.delete();
            exp_q1.delete();
            exp_q3.delete();
        end
    endtask

    // ---------------- directed vectors ----------------
    initial begin
        repeat (2) @(posedge clk);
        #1;

        tname = "reset";
        rows = '{R_IDL, R_IDL, R_IDL};
        load(3'b111);
        issue(4'b0000, 4'b0000, 16'h0000, 0, 3);

        tname = "ld_op_change";
        rows = '{R_IDL, R_EA, R_CAP, R_IDL, R_IDL, R_IDL, R_IDL}; load(3'b001);
        rows = '{R_IDL, R_EA, R_WT, R_CAP, R_IDL, R_IDL, R_IDL};  load(3'b010);
        rows = '{R_IDL, R_EA, R_WT, R_WT, R_WT, R_CAP, R_IDL};    load(3'b100);
        issue(OP_LD, OP_ST, 16'h0001, -1, 7);

        tname = "ldr";
        rows = '{R_IDL, R_EA, R_CAP, R_IDL, R_IDL, R_IDL, R_IDL}; load(3'b001);
        rows = '{R_IDL, R_EA, R_WT, R_CAP, R_IDL, R_IDL, R_IDL};  load(3'b010);
        rows = '{R_IDL, R_EA, R_WT, R_WT, R_WT, R_CAP, R_IDL};    load(3'b100);
        issue(OP_LDR, OP_LDR, 16'h0001, -1, 7);

        tname = "st";
        rows = '{R_IDL, R_EA, R_WR, R_IDL}; load(3'b111);
        issue(OP_ST, OP_ST, 16'h0001, -1, 4);

        tname = "str";
        rows = '{R_IDL, R_EA, R_WR, R_IDL}; load(3'b111);
        issue(OP_STR, OP_STR, 16'h0001, -1, 4);

        tname = "sti";
        rows = '{R_IDL, R_EA, R_IND, R_WR, R_IDL, R_IDL, R_IDL, R_IDL};  load(3'b001);
        rows = '{R_IDL, R_EA, R_WT, R_IND, R_WR, R_IDL, R_IDL, R_IDL};   load(3'b010);
        rows = '{R_IDL, R_EA, R_WT, R_WT, R_WT, R_IND, R_WR, R_IDL};     load(3'b100);
        issue(OP_STI, OP_STI, 16'h0001, -1, 8);

        tname = "ldi";
        rows = '{R_IDL, R_EA, R_IND, R_CAP, R_IDL, R_IDL, R_IDL, R_IDL,
                 R_IDL, R_IDL, R_IDL};                                   load(3'b001);
        rows = '{R_IDL, R_EA, R_WT, R_IND, R_WT, R_CAP, R_IDL, R_IDL,
                 R_IDL, R_IDL, R_IDL};                                   load(3'b010);
        rows = '{R_IDL, R_EA, R_WT, R_WT, R_WT, R_IND, R_WT, R_WT,
                 R_WT, R_CAP, R_IDL};                                    load(3'b100);
        issue(OP_LDI, OP_LDI, 16'h0001, -1, 11);

        tname = "badop_add";
        rows = '{R_IDL, R_BAD, R_IDL}; load(3'b111);
        issue(4'b0001, 4'b0001, 16'h0001, -1, 3);

        tname = "badop_lea";
        rows = '{R_IDL, R_BAD, R_IDL}; load(3'b111);
        issue(4'b1110, 4'b1110, 16'h0001, -1, 3);

        tname = "start_while_busy";
        rows = '{R_IDL, R_EA, R_WR, R_IDL, R_IDL}; load(3'b111);
        issue(OP_ST, OP_LD, 16'h0003, -1, 5);

        tname = "back_to_back";
        rows = '{R_IDL, R_EA, R_WR, R_IDL, R_EA, R_WR, R_IDL}; load(3'b111);
        issue(OP_ST, OP_ST, 16'h003F, -1, 7);

        tname = "reset_mid_str";
        rows = '{R_IDL, R_EA, R_IDL, R_IDL}; load(3'b111);
        issue(OP_STR, OP_STR, 16'h0001, 1, 4);

        tname = "reset_mid_ldi";
        rows = '{R_IDL, R_EA, R_IND, R_CAP, R_IDL, R_IDL}; load(3'b001);
        rows = '{R_IDL, R_EA, R_WT, R_IND, R_IDL, R_IDL};  load(3'b010);
        rows = '{R_IDL, R_EA, R_WT, R_WT, R_IDL, R_IDL};   load(3'b100);
        issue(OP_LDI, OP_LDI, 16'h0001, 3, 6);

        tname = "after_reset_ld";
        rows = '{R_IDL, R_EA, R_CAP, R_IDL, R_IDL, R_IDL, R_IDL}; load(3'b001);
        rows = '{R_IDL, R_EA, R_WT, R_CAP, R_IDL, R_IDL, R_IDL};  load(3'b010);
        rows = '{R_IDL, R_EA, R_WT, R_WT, R_WT, R_CAP, R_IDL};    load(3'b100);
        issue(OP_LD, OP_LD, 16'h0001, -1, 7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
